// File: rtl/fifo_buffer_v2.sv
// fifo_buffer_v2
//   Parametrised synchronous FIFO used between the UART byte engines and the
//   host-side register interface, one instance per direction. It offers a
//   registered-read mode and a first-word-fall-through mode, programmable
//   almost-full/almost-empty thresholds, an occupancy count, sticky
//   overflow/underflow flags and a synchronous flush.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   flush          in   synchronous clear of contents (error flags kept)
//   clear_errors   in   synchronous clear of overflow/underflow
//   enqueue        in   write data
//   req_enqueue    in   write request
//   req_dequeue    in   read request (FWFT=0) / pop acknowledge (FWFT=1)
//   dequeue        out  read data
//   dequeue_valid  out  dequeue holds valid data
//   count          out  occupancy 0..MAX_ELEMENTS
//   isEmpty/isFull out  count==0 / count==MAX_ELEMENTS
//   almostEmpty    out  count <= ALMOST_EMPTY_LEVEL
//   almostFull     out  count >= ALMOST_FULL_LEVEL
//   overflow       out  sticky: write dropped because FIFO was full
//   underflow      out  sticky: read requested while FIFO was empty
module fifo_buffer_v2 #(
  parameter int DATA_BITS          = 8,
  parameter int MAX_ELEMENTS       = 16,
  parameter int ALMOST_FULL_LEVEL  = MAX_ELEMENTS - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter bit FWFT               = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 clear_errors,
  input  logic [DATA_BITS-1:0]                 enqueue,
  input  logic                                 req_enqueue,
  input  logic                                 req_dequeue,
  output logic [DATA_BITS-1:0]                 dequeue,
  output logic                                 dequeue_valid,
  output logic [$clog2(MAX_ELEMENTS+1)-1:0]    count,
  output logic                                 isEmpty,
  output logic                                 isFull,
  output logic                                 almostEmpty,
  output logic                                 almostFull,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int CountW = $clog2(MAX_ELEMENTS + 1);
  localparam int PtrW   = $clog2(MAX_ELEMENTS);

  localparam logic [CountW-1:0] CountMax  = CountW'(MAX_ELEMENTS);
  localparam logic [CountW-1:0] AfLevel   = CountW'(ALMOST_FULL_LEVEL);
  localparam logic [CountW-1:0] AeLevel   = CountW'(ALMOST_EMPTY_LEVEL);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(MAX_ELEMENTS - 1);

  logic [DATA_BITS-1:0] mem [MAX_ELEMENTS];

  logic [PtrW-1:0]      frontQ, frontD;
  logic [PtrW-1:0]      rearQ, rearD;
  logic [CountW-1:0]    countQ, countD;
  logic [DATA_BITS-1:0] dataQ, dataD;
  logic                 validQ, validD;
  logic                 overflowQ, overflowD;
  logic                 underflowQ, underflowD;

  logic emptyInt, fullInt;
  logic readAccept, writeAccept;

  // Depth need not be a power of two, so pointers wrap by explicit compare.
  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign emptyInt = (countQ == '0);
  assign fullInt  = (countQ == CountMax);

  // A write into a full FIFO is still accepted when a read frees the head
  // slot in the same cycle; flush suppresses both requests.
  assign readAccept  = req_dequeue && !emptyInt && !flush;
  assign writeAccept = req_enqueue && (!fullInt || readAccept) && !flush;

  always_comb begin
    frontD     = frontQ;
    rearD      = rearQ;
    countD     = countQ;
    dataD      = dataQ;
    validD     = 1'b0;
    overflowD  = overflowQ && !clear_errors;
    underflowD = underflowQ && !clear_errors;

    if (flush) begin
      frontD = '0;
      rearD  = '0;
      countD = '0;
    end else begin
      if (readAccept) begin
        frontD = nextPtr(frontQ);
        dataD  = mem[frontQ];
        validD = 1'b1;
      end
      if (writeAccept) begin
        rearD = nextPtr(rearQ);
      end
      unique case ({writeAccept, readAccept})
        2'b10:   countD = countQ + CountW'(1);
        2'b01:   countD = countQ - CountW'(1);
        default: countD = countQ;
      endcase
      // A new error wins over clear_errors in the same cycle.
      if (req_enqueue && !writeAccept) begin
        overflowD = 1'b1;
      end
      if (req_dequeue && emptyInt) begin
        underflowD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frontQ     <= '0;
      rearQ      <= '0;
      countQ     <= '0;
      dataQ      <= '0;
      validQ     <= 1'b0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      frontQ     <= frontD;
      rearQ      <= rearD;
      countQ     <= countD;
      dataQ      <= dataD;
      validQ     <= validD;
      overflowQ  <= overflowD;
      underflowQ <= underflowD;
    end
  end

  // Storage is not reset; occupancy tracking makes stale contents invisible.
  always_ff @(posedge clk) begin
    if (writeAccept) begin
      mem[rearQ] <= enqueue;
    end
  end

  // In fall-through mode the head word is presented combinationally from
  // the array; otherwise the registered read word is shown.
  always_comb begin
    if (FWFT) begin
      dequeue       = emptyInt ? '0 : mem[frontQ];
      dequeue_valid = !emptyInt;
    end else begin
      dequeue       = dataQ;
      dequeue_valid = validQ;
    end
  end

  assign count       = countQ;
  assign isEmpty     = emptyInt;
  assign isFull      = fullInt;
  assign almostEmpty = (countQ <= AeLevel);
  assign almostFull  = (countQ >= AfLevel);
  assign overflow    = overflowQ;
  assign underflow   = underflowQ;

endmodule
